// File: rtl/apb_gpio_slave.sv
// rtl/apb_gpio_slave.sv - APB slave exposing a GPIO block (OUT, DIR, IN, IRQ_EN, IRQ_STAT)
//
// Purpose : APB register slave with a four-state transfer FSM and programmable wait states.
//           Each transfer spends one cycle in SETUP and WAIT_STATES cycles in WAIT.
//           PREADY, PSLVERR and PRDATA are registered and are asserted only in DONE.
//           Writes commit on the clock edge that ends DONE.
//           Optional interrupt logic is built only when the macro GPIO_IRQ_EN is defined.
//           Without it, IRQ_EN and IRQ_STAT read 0 and IRQ is tied low.
// Ports   : PCLK, PRESETn (async, active-low) ; APB slave: PSEL, PENABLE, PWRITE, PADDR,
//           PWDATA, PSTRB -> PRDATA, PREADY, PSLVERR ; GPIO_IN (async pins) ;
//           GPIO_OUT, GPIO_OE (pin drive) ; IRQ (level interrupt, registered).
// Notes   : ADDRESS_WIDTH must be at least 5 and GPIO_WIDTH must not exceed DATA_WIDTH.
module apb_gpio_slave #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int STRB_WIDTH    = 4,
  parameter int GPIO_WIDTH    = 16,
  parameter int WAIT_STATES   = 1
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [ADDRESS_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0]    PWDATA,
  input  logic [STRB_WIDTH-1:0]    PSTRB,
  output logic [DATA_WIDTH-1:0]    PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  input  logic [GPIO_WIDTH-1:0]    GPIO_IN,
  output logic [GPIO_WIDTH-1:0]    GPIO_OUT,
  output logic [GPIO_WIDTH-1:0]    GPIO_OE,
  output logic                     IRQ
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_WAIT, ST_DONE} state_t;

  localparam logic [2:0]               WS        = 3'(WAIT_STATES);
  localparam logic [ADDRESS_WIDTH-3:0] LAST_WORD = (ADDRESS_WIDTH-2)'(4);

  state_t                  r_state;
  logic [2:0]              r_wait_cnt;
  logic                    r_pready;
  logic                    r_pslverr;
  logic [DATA_WIDTH-1:0]   r_prdata;
  // Write captured on entry to DONE.
  // r_wr_pend is high only during the DONE cycle.
  logic                    r_wr_pend;
  logic [2:0]              r_wr_idx;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic [DATA_WIDTH-1:0]   r_wr_mask;
  logic [GPIO_WIDTH-1:0]   r_out;
  logic [GPIO_WIDTH-1:0]   r_dir;
  logic [GPIO_WIDTH-1:0]   r_sync1;
  logic [GPIO_WIDTH-1:0]   r_sync2;

  logic [GPIO_WIDTH-1:0]   w_irq_en_rd;
  logic [GPIO_WIDTH-1:0]   w_irq_stat_rd;
  logic [2:0]              w_idx;
  logic                    w_bad_addr;
  logic                    w_err;
  logic                    w_enter_done;
  logic [GPIO_WIDTH-1:0]   w_rd_sel;
  logic [DATA_WIDTH-1:0]   w_rdata;
  logic [DATA_WIDTH-1:0]   w_mask;
  logic                    w_unused_addr;

  // Replace the byte lanes selected by the mask.
  // Bits above GPIO_WIDTH are dropped by the final cast.
  function automatic logic [GPIO_WIDTH-1:0] f_merge(input logic [GPIO_WIDTH-1:0] old_v,
                                                     input logic [DATA_WIDTH-1:0] wd,
                                                     input logic [DATA_WIDTH-1:0] m);
    logic [DATA_WIDTH-1:0] t;
    t = (DATA_WIDTH'(old_v) & ~m) | (wd & m);
    return GPIO_WIDTH'(t);
  endfunction

  assign w_idx         = PADDR[4:2];
  assign w_bad_addr    = PADDR[ADDRESS_WIDTH-1:2] > LAST_WORD;
  assign w_err         = w_bad_addr | (PWRITE & (w_idx == 3'd2)) | (~PWRITE & (|PSTRB));
  assign w_unused_addr = ^PADDR[1:0];

  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_lane_mask
    assign w_mask[g] = PSTRB[g/8];
  end

  always_comb begin
    w_rd_sel = '0;
    case (w_idx)
      3'd0:    w_rd_sel = r_out;
      3'd1:    w_rd_sel = r_dir;
      3'd2:    w_rd_sel = r_sync2;
      3'd3:    w_rd_sel = w_irq_en_rd;
      3'd4:    w_rd_sel = w_irq_stat_rd;
      default: w_rd_sel = '0;
    endcase
  end

  assign w_rdata = DATA_WIDTH'(w_rd_sel);

  // The access phase completes on this edge.
  // With no wait states, the path is SETUP->DONE; otherwise it is WAIT->DONE.
  assign w_enter_done = PSEL & PENABLE &
                        (((r_state == ST_SETUP) && (WAIT_STATES == 0)) ||
                         ((r_state == ST_WAIT) && (r_wait_cnt == WS)));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 3'd0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_prdata   <= '0;
      r_wr_pend  <= 1'b0;
      r_wr_idx   <= 3'd0;
      r_wr_data  <= '0;
      r_wr_mask  <= '0;
    end else begin
      r_pready  <= w_enter_done;
      r_pslverr <= w_enter_done & w_err;
      r_prdata  <= (w_enter_done && !w_err) ? w_rdata : '0;
      r_wr_pend <= w_enter_done & PWRITE & ~w_err;
      if (w_enter_done) begin
        r_wr_idx  <= w_idx;
        r_wr_data <= PWDATA;
        r_wr_mask <= w_mask;
      end
      case (r_state)
        ST_IDLE: begin
          if (PSEL && !PENABLE) r_state <= ST_SETUP;
        end
        ST_SETUP: begin
          if (!PSEL) begin
            r_state <= ST_IDLE;
          end else if (PENABLE) begin
            if (WAIT_STATES == 0) begin
              r_state <= ST_DONE;
            end else begin
              r_state    <= ST_WAIT;
              r_wait_cnt <= 3'd1;
            end
          end
        end
        ST_WAIT: begin
          if (!PSEL) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 3'd0;
          end else if (w_enter_done) begin
            r_state    <= ST_DONE;
            r_wait_cnt <= 3'd0;
          end else if (r_wait_cnt != WS) begin
            r_wait_cnt <= r_wait_cnt + 3'd1;
          end
        end
        ST_DONE: begin
          if (PSEL && !PENABLE) r_state <= ST_SETUP;
          else                  r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_out   <= '0;
      r_dir   <= '0;
    end else begin
      r_sync1 <= GPIO_IN;
      r_sync2 <= r_sync1;
      if (r_wr_pend) begin
        case (r_wr_idx)
          3'd0:    r_out <= f_merge(r_out, r_wr_data, r_wr_mask);
          3'd1:    r_dir <= f_merge(r_dir, r_wr_data, r_wr_mask);
          default: ;
        endcase
      end
    end
  end

`ifdef GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] r_irq_en;
  logic [GPIO_WIDTH-1:0] r_irq_stat;
  logic [GPIO_WIDTH-1:0] r_sync3;
  logic                  r_irq;
  logic [GPIO_WIDTH-1:0] w_set;
  logic [GPIO_WIDTH-1:0] w_clr;

  // Edge detection uses the synchronized value and its one-cycle-delayed copy.
  assign w_set = r_sync2 & ~r_sync3 & r_irq_en;
  assign w_clr = (r_wr_pend && (r_wr_idx == 3'd4)) ? GPIO_WIDTH'(r_wr_data & r_wr_mask) : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_irq_en   <= '0;
      r_irq_stat <= '0;
      r_sync3    <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_sync3 <= r_sync2;
      if (r_wr_pend && (r_wr_idx == 3'd3)) r_irq_en <= f_merge(r_irq_en, r_wr_data, r_wr_mask);
      // Set is applied after clear, so a coincident edge is not lost.
      r_irq_stat <= (r_irq_stat & ~w_clr) | w_set;
      r_irq      <= |(r_irq_stat & r_irq_en);
    end
  end

  assign w_irq_en_rd   = r_irq_en;
  assign w_irq_stat_rd = r_irq_stat;
  assign IRQ           = r_irq;
`else
  assign w_irq_en_rd   = '0;
  assign w_irq_stat_rd = '0;
  assign IRQ           = 1'b0;
`endif

  assign PRDATA   = r_prdata;
  assign PREADY   = r_pready;
  assign PSLVERR  = r_pslverr;
  assign GPIO_OUT = r_out;
  assign GPIO_OE  = r_dir;

endmodule

// File: tb/tb_apb_gpio_slave.sv
// tb/tb_apb_gpio_slave.sv - self-checking bench for apb_gpio_slave
module tb_apb_gpio_slave;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int GW = 16;
  localparam int WS = 1;
  localparam logic [31:0] GMASK = 32'h0000FFFF;
`ifdef GPIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic          PCLK = 1'b0;
  logic          PRESETn;
  logic          PSEL = 1'b0;
  logic          PENABLE = 1'b0;
  logic          PWRITE = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic [DW-1:0] PWDATA = '0;
  logic [SW-1:0] PSTRB = '0;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  logic [GW-1:0] GPIO_IN = '0;
  logic [GW-1:0] GPIO_OUT;
  logic [GW-1:0] GPIO_OE;
  logic          IRQ;

  int n_cmp = 0;
  int n_bad = 0;

  apb_gpio_slave #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STRB_WIDTH(SW), .GPIO_WIDTH(GW), .WAIT_STATES(WS)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT), .GPIO_OE(GPIO_OE), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    bit          chk_rd;
    logic [31:0] rd;
    bit          err;
    logic [31:0] out;
    logic [31:0] oe;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Full APB transfer: setup, access, wait for PREADY (bounded), then idle.
  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] strb, output logic [31:0] rd, output logic err);
    int lat;
    bit got;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    lat = 0; got = 1'b0; rd = '0; err = 1'b0;
    while (!got && lat < 40) begin
      @(negedge PCLK);
      lat++;
      if (PREADY === 1'b1) begin
        got = 1'b1; rd = PRDATA; err = PSLVERR;
      end
    end
    chk("pready_seen", 32'(got), 32'd1);
    if (got) chk("access_latency", 32'(lat - 1), 32'(WS + 1));
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = '0;
    @(negedge PCLK);
    chk("pready_one_cycle", 32'(PREADY), 32'd0);
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] wd,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r & GMASK;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    m = 0;
    for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8*b));
    return m;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        er;
    vec_t        vt[17];
    bit          saw;
    bit          got;
    logic [31:0] m_out, m_dir, m_in, m_en, m_stat, nin, addr, wd, exp_rd, word;
    logic [3:0]  strb;
    bit          wr, e;
    int          sel;

    vt[0]  = '{1'b1, 32'h00, 32'h0000A5A5, 4'h3, 1'b0, 32'h0,        1'b0, 32'hA5A5, 32'h0000};
    vt[1]  = '{1'b1, 32'h04, 32'h0000FFFF, 4'h1, 1'b0, 32'h0,        1'b0, 32'hA5A5, 32'h00FF};
    vt[2]  = '{1'b0, 32'h04, 32'h0,        4'h0, 1'b1, 32'h000000FF, 1'b0, 32'hA5A5, 32'h00FF};
    vt[3]  = '{1'b0, 32'h00, 32'h0,        4'h0, 1'b1, 32'h0000A5A5, 1'b0, 32'hA5A5, 32'h00FF};
    vt[4]  = '{1'b0, 32'h08, 32'h0,        4'h0, 1'b1, 32'h00005A5A, 1'b0, 32'hA5A5, 32'h00FF};
    vt[5]  = '{1'b1, 32'h08, 32'h00001234, 4'hF, 1'b0, 32'h0,        1'b1, 32'hA5A5, 32'h00FF};
    vt[6]  = '{1'b0, 32'h08, 32'h0,        4'h0, 1'b1, 32'h00005A5A, 1'b0, 32'hA5A5, 32'h00FF};
    vt[7]  = '{1'b0, 32'h14, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1, 32'hA5A5, 32'h00FF};
    vt[8]  = '{1'b0, 32'h00, 32'h0,        4'h1, 1'b0, 32'h0,        1'b1, 32'hA5A5, 32'h00FF};
    vt[9]  = '{1'b1, 32'h00, 32'hFFFFFFFF, 4'hC, 1'b0, 32'h0,        1'b0, 32'hA5A5, 32'h00FF};
    vt[10] = '{1'b1, 32'h01, 32'h00003C00, 4'h2, 1'b0, 32'h0,        1'b0, 32'h3CA5, 32'h00FF};
    vt[11] = '{1'b1, 32'h20, 32'h0000FFFF, 4'hF, 1'b0, 32'h0,        1'b1, 32'h3CA5, 32'h00FF};
    vt[12] = '{1'b1, 32'h04, 32'h12340000, 4'hF, 1'b0, 32'h0,        1'b0, 32'h3CA5, 32'h0000};
    vt[13] = '{1'b0, 32'h04, 32'h0,        4'h0, 1'b1, 32'h0,        1'b0, 32'h3CA5, 32'h0000};
    vt[14] = '{1'b1, 32'h0C, 32'h0,        4'hF, 1'b0, 32'h0,        1'b0, 32'h3CA5, 32'h0000};
    vt[15] = '{1'b0, 32'h10, 32'h0,        4'h0, 1'b1, 32'h0,        1'b0, 32'h3CA5, 32'h0000};
    vt[16] = '{1'b0, 32'h0C, 32'h0,        4'h0, 1'b1, 32'h0,        1'b0, 32'h3CA5, 32'h0000};

    // Reset state, observed before any clock edge has a chance to matter.
    PRESETn = 1'b1;
    #1 PRESETn = 1'b0;
    #2;
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pready", 32'(PREADY), 32'h0);
    chk("rst_pslverr", 32'(PSLVERR), 32'h0);
    chk("rst_gpio_out", 32'(GPIO_OUT), 32'h0);
    chk("rst_gpio_oe", 32'(GPIO_OE), 32'h0);
    chk("rst_irq", 32'(IRQ), 32'h0);
    GPIO_IN = 16'h5A5A;
    @(negedge PCLK); PRESETn = 1'b1;
    repeat (3) @(negedge PCLK);

    for (int i = 0; i < 17; i++) begin
      apb(vt[i].wr, vt[i].addr, vt[i].wd, vt[i].strb, rd, er);
      chk($sformatf("vec%0d_pslverr", i), 32'(er), 32'(vt[i].err));
      if (vt[i].chk_rd) chk($sformatf("vec%0d_prdata", i), rd, vt[i].rd);
      chk($sformatf("vec%0d_gpio_out", i), 32'(GPIO_OUT), vt[i].out);
      chk($sformatf("vec%0d_gpio_oe", i), 32'(GPIO_OE), vt[i].oe);
    end

    // PSEL dropped in SETUP, then in WAIT: no completion, no write.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'hFFFF; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PSEL = 1'b0;
    saw = 1'b0;
    repeat (5) begin @(negedge PCLK); if (PREADY) saw = 1'b1; end
    chk("abort_setup_pready", 32'(saw), 32'h0);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    saw = 1'b0;
    repeat (5) begin @(negedge PCLK); if (PREADY) saw = 1'b1; end
    chk("abort_wait_pready", 32'(saw), 32'h0);
    chk("abort_gpio_out", 32'(GPIO_OUT), 32'h3CA5);

    // Reset pulsed in the middle of a write to DIR.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h04; PWDATA = 32'hFFFF; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #2;
    PRESETn = 1'b0;
    #1;
    chk("midrst_pready", 32'(PREADY), 32'h0);
    chk("midrst_prdata", PRDATA, 32'h0);
    chk("midrst_pslverr", 32'(PSLVERR), 32'h0);
    chk("midrst_gpio_out", 32'(GPIO_OUT), 32'h0);
    chk("midrst_gpio_oe", 32'(GPIO_OE), 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);
    chk("midrst_no_write", 32'(GPIO_OE), 32'h0);
    apb(1'b1, 32'h00, 32'h1111, 4'hF, rd, er);
    chk("postrst_err", 32'(er), 32'h0);
    chk("postrst_gpio_out", 32'(GPIO_OUT), 32'h1111);

    // Interrupt path (GPIO_IN[0] is 0 here).
    apb(1'b1, 32'h0C, 32'h1, 4'hF, rd, er);
    chk("irqen_wr_err", 32'(er), 32'h0);
    @(negedge PCLK);
    GPIO_IN[0] = 1'b1;
`ifdef GPIO_IRQ_EN
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin @(negedge PCLK); if (IRQ) got = 1'b1; end
    chk("irq_rise_within_4", 32'(got), 32'h1);
    apb(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    chk("irq_stat_read", rd, 32'h1);
    apb(1'b1, 32'h10, 32'h1, 4'h1, rd, er);
    repeat (2) @(negedge PCLK);
    chk("irq_cleared", 32'(IRQ), 32'h0);
    apb(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    chk("irq_stat_cleared", rd, 32'h0);
    // An edge detected on the same edge as a W1C commit: set must win.
    GPIO_IN[0] = 1'b0;
    repeat (4) @(negedge PCLK);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h10; PWDATA = 32'h1; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    GPIO_IN[0] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin @(negedge PCLK); if (PREADY) got = 1'b1; end
    chk("race_pready", 32'(got), 32'h1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = '0;
    repeat (2) @(negedge PCLK);
    chk("race_irq", 32'(IRQ), 32'h1);
    apb(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    chk("race_set_wins", rd, 32'h1);
`else
    repeat (6) @(negedge PCLK);
    chk("irq_tied_low", 32'(IRQ), 32'h0);
    apb(1'b0, 32'h0C, 32'h0, 4'h0, rd, er);
    chk("irqen_reads_zero", rd, 32'h0);
    chk("irqen_read_err", 32'(er), 32'h0);
    apb(1'b1, 32'h10, 32'h1, 4'hF, rd, er);
    chk("irqstat_wr_err", 32'(er), 32'h0);
    apb(1'b0, 32'h10, 32'h0, 4'h0, rd, er);
    chk("irqstat_reads_zero", rd, 32'h0);
`endif

    // Randomized traffic against a register-level model.
    @(negedge PCLK); PRESETn = 1'b0;
    @(negedge PCLK); PRESETn = 1'b1;
    m_out = 0; m_dir = 0; m_en = 0; m_stat = 0; m_in = 32'(GPIO_IN);
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        nin = $urandom & GMASK;
        if (IRQ_ON) m_stat = m_stat | (nin & ~m_in & m_en);
        m_in = nin;
        GPIO_IN = nin[15:0];
      end
      sel = $urandom_range(0, 6);
      if (sel < 5)       addr = 32'(sel * 4) + 32'($urandom_range(0, 3));
      else if (sel == 5) addr = 32'h14 + 32'($urandom_range(0, 11));
      else               addr = $urandom | 32'h100;
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (wr) strb = 4'($urandom_range(0, 15));
      else    strb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      word = addr >> 2;
      e = (word > 4) || (wr && word == 2) || (!wr && strb != 0);
      case (word)
        0:       exp_rd = m_out;
        1:       exp_rd = m_dir;
        2:       exp_rd = m_in;
        3:       exp_rd = IRQ_ON ? m_en : 32'h0;
        4:       exp_rd = IRQ_ON ? m_stat : 32'h0;
        default: exp_rd = 32'h0;
      endcase
      if (wr && !e) begin
        case (word)
          0: m_out = lanes(m_out, wd, strb);
          1: m_dir = lanes(m_dir, wd, strb);
          3: if (IRQ_ON) m_en = lanes(m_en, wd, strb);
          4: if (IRQ_ON) m_stat = m_stat & ~(wd & lane_mask(strb) & GMASK);
          default: ;
        endcase
      end
      apb(wr, addr, wd, strb, rd, er);
      chk($sformatf("rnd%0d_pslverr a=%0h w=%0d s=%0h", it, addr, wr, strb), 32'(er), 32'(e));
      if (!wr && !e) chk($sformatf("rnd%0d_prdata a=%0h", it, addr), rd, exp_rd);
      if (word > 4)  chk($sformatf("rnd%0d_prdata_bad a=%0h", it, addr), rd, 32'h0);
      repeat (2) @(negedge PCLK);
      chk($sformatf("rnd%0d_gpio_out", it), 32'(GPIO_OUT), m_out);
      chk($sformatf("rnd%0d_gpio_oe", it), 32'(GPIO_OE), m_dir);
      chk($sformatf("rnd%0d_irq", it), 32'(IRQ), 32'((m_stat & m_en) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
